// File: rtl/qed_dup_buffer_if.sv
// Fetch-side bundle between the IFU QED tap, the duplication buffer and the QED instruction mux.
interface qed_dup_buffer_if #(
  parameter int unsigned IWIDTH = 32,
  parameter int unsigned CW     = 8
);
  logic              exec_dup;
  logic              if_stall;
  logic              flush;
  logic [IWIDTH-1:0] ifu_qed_instruction;
  logic [IWIDTH-1:0] qic_qimux_instruction;
  logic              vld_out;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              parity_err;

  modport master (
    output exec_dup, if_stall, flush, ifu_qed_instruction,
    input  qic_qimux_instruction, vld_out, count, full, empty, overflow, parity_err
  );

  modport slave (
    input  exec_dup, if_stall, flush, ifu_qed_instruction,
    output qic_qimux_instruction, vld_out, count, full, empty, overflow, parity_err
  );
endinterface

// File: rtl/qed_dup_buffer.sv
// QED instruction duplication buffer: records non-NOP fetches in original mode, replays them in duplicate mode.
// Optional per-entry even parity with sticky parity_err when QED_DUP_BUF_PARITY_EN is defined.
module qed_dup_buffer #(
  parameter int unsigned IWIDTH  = 32,
  parameter int unsigned DEPTH   = 128,
  parameter logic [6:0]  NOP_OPC = 7'h7F
) (
  input logic              clk,
  input logic              rst_n,
  qed_dup_buffer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef QED_DUP_BUF_PARITY_EN
  localparam int unsigned MW = IWIDTH + 1;
`else
  localparam int unsigned MW = IWIDTH;
`endif

  logic [MW-1:0] mem [DEPTH];
  logic [AW:0]   head_q;
  logic [AW:0]   tail_q;
  logic          overflow_q;
  logic [MW-1:0] rd_entry_c;
  logic [MW-1:0] wr_entry_c;
  logic          is_nop_c;
  logic          active_c;
  logic          full_c;
  logic          empty_c;
  logic          push_c;
  logic          pop_c;
  logic          drop_c;

  // Wrap bit distinguishes full from empty so every slot is usable.
  always_comb begin
    is_nop_c = (bus.ifu_qed_instruction[6:0] == NOP_OPC);
    active_c = ~bus.flush & ~bus.if_stall;
    full_c   = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    empty_c  = (head_q == tail_q);
    push_c   = active_c & ~bus.exec_dup & ~is_nop_c & ~full_c;
    pop_c    = active_c &  bus.exec_dup & ~empty_c;
    drop_c   = active_c & ~bus.exec_dup & ~is_nop_c &  full_c;
    rd_entry_c = mem[head_q[AW-1:0]];
`ifdef QED_DUP_BUF_PARITY_EN
    wr_entry_c = {^bus.ifu_qed_instruction, bus.ifu_qed_instruction};
`else
    wr_entry_c = bus.ifu_qed_instruction;
`endif
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[tail_q[AW-1:0]] <= wr_entry_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_c) tail_q <= tail_q + (AW+1)'(1);
      if (pop_c)  head_q <= head_q + (AW+1)'(1);
      if (drop_c) overflow_q <= 1'b1;
    end
  end

`ifdef QED_DUP_BUF_PARITY_EN
  logic parity_err_q;

  // Data plus stored even-parity bit must XOR to zero on a clean entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     parity_err_q <= 1'b0;
    else if (bus.flush)             parity_err_q <= 1'b0;
    else if (pop_c && ^rd_entry_c)  parity_err_q <= 1'b1;
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.qic_qimux_instruction = push_c ? bus.ifu_qed_instruction :
                                     pop_c  ? rd_entry_c[IWIDTH-1:0]  :
                                              IWIDTH'(NOP_OPC);
  assign bus.vld_out  = push_c | pop_c;
  assign bus.count    = CW'(tail_q - head_q);
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.overflow = overflow_q;
endmodule

// File: doc/qed_dup_buffer.md
# qed_dup_buffer

Parametrised instruction duplication buffer for the QED front end. In original mode it records every non-NOP instruction fetched and passes it straight through to the QED instruction mux; in duplicate mode it replays the recorded instructions in order. It generalises the fixed 32-bit, 128-slot buffer to configurable width and depth, uses every slot, and adds occupancy reporting, a sticky overflow flag and a synchronous flush. It sits between the IFU QED tap and the QED instruction mux.

## Interface
- IWIDTH, 32, instruction width in bits; must be ≥ 7.
- DEPTH, 128, number of stored entries; power of two, ≥ 2.
- NOP_OPC, 7'h7F, value of bits [6:0] that marks a NOP.
- CW, $clog2(DEPTH)+1, derived width of the `count` port (localparam).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- exec_dup  in  1  0 = original mode (record), 1 = duplicate mode (replay).
- if_stall  in  1  fetch stall; no push or pop while high.
- flush  in  1  synchronous clear of buffer contents and pointers.
- ifu_qed_instruction  in  IWIDTH  instruction from the IFU.
- qic_qimux_instruction  out  IWIDTH  instruction to the QED mux.
- vld_out  out  1  `qic_qimux_instruction` carries a real instruction this cycle.
- count  out  CW  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a non-NOP record was dropped because the buffer was full.
- parity_err  out  1  sticky parity error on replay (see Configuration).

## Operation
- Storage is DEPTH×IWIDTH with asynchronous read.
- Head and tail pointers are log2(DEPTH)+1 bits wide, and the top bit is the wrap bit. `full` is true when the index bits are equal and the wrap bits differ. All DEPTH slots are usable.
- is_nop = (ifu_qed_instruction[6:0] == NOP_OPC).
- push = ~flush & ~exec_dup & ~if_stall & ~is_nop & ~full.
- pop = ~flush & exec_dup & ~if_stall & ~empty.
- drop = ~flush & ~exec_dup & ~if_stall & ~is_nop & full. A drop sets `overflow`, and `overflow` stays set until reset or flush.
- qic_qimux_instruction:
  - on push, ifu_qed_instruction (pass-through in the same cycle);
  - else on pop, the entry at head;
  - else the IWIDTH-bit zero-extended NOP_OPC.
- vld_out = push | pop.
- `count` increments on push and decrements on pop. Push and pop are mutually exclusive because `exec_dup` selects one, so both can never happen in the same cycle.
- Pointers wrap modulo 2·DEPTH, with no special case at the boundary.
- `flush` zeroes the head, tail, overflow and parity_err bits at the next edge. Memory contents are not cleared. Flush takes priority over any push or pop in the same cycle.
- A mode change takes effect in the same cycle and needs no drain or handshake.

## Timing
- Reset (async, rst_n low): head = tail = 0, count = 0, empty = 1, full = 0, overflow = 0, parity_err = 0.
  - Because the outputs are combinational from the inputs, while rst_n is low `vld_out` follows push/pop with empty=1 and full=0. Consumers must ignore `vld_out` during reset.
- Reset asserted mid-replay discards every stored entry immediately.
- Outputs `qic_qimux_instruction` and `vld_out` are combinational, with zero-cycle latency.
- `count`, `full`, `empty` and the flags are registered and update one cycle after the push, pop, drop or flush edge.
- A pushed entry can be popped on the next cycle at the earliest.

## Configuration
- QED_DUP_BUF_PARITY_EN defined:
  - every entry stores one extra even-parity bit computed on push;
  - on each pop the stored parity is recomputed and compared, and a mismatch sets `parity_err` at the next edge;
  - `parity_err` stays set until reset or flush.
- Not defined:
  - there is no parity storage;
  - `parity_err` is tied to 0.

## Test plan
- Reset, then push 0x00000013, 0x00100093 and 0x00200113 with exec_dup=0. Expect pass-through outputs with vld_out=1 each cycle, then count=3. Switch to exec_dup=1 and expect the same three values replayed in order with vld_out=1; the fourth cycle gives 0x7F with vld_out=0 and empty=1.
- Fetch NOPs (bits[6:0]=7F) with exec_dup=0. Expect vld_out=0, output 0x7F, and count unchanged.
- Push DEPTH entries. Expect full=1 and count=DEPTH. One more non-NOP fetch must be dropped (vld_out=0) and set overflow=1; after popping all DEPTH entries the original order must come back intact across the pointer wrap.
- Hold if_stall=1 during record and during replay. Expect no pointer movement, vld_out=0 and count constant; resuming continues from the same entry.
- With 5 entries stored and overflow=1, assert flush together with exec_dup=1. Expect no pop, then count=0, empty=1 and overflow=0 on the next cycle. Deasserting rst_n mid-replay likewise forces count=0 asynchronously.
- With QED_DUP_BUF_PARITY_EN defined, force a bit flip in a stored entry and pop it. Expect parity_err=1 the cycle after the pop, held until flush.
